control_sequencer: RTL and testbench

//  Micro-op sequencer directly upstream of the microcode store. Holds the opcode register,

---
 rtl/control_sequencer_pkg.sv | 57 +++++
 rtl/ctrl_word_decoder.sv | 76 +++++++
 rtl/control_sequencer.sv | 104 ++++++++++
 tb/tb_control_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the micro-op sequencer and the microcode store:
// opcode values, plane encodings, register-select and misc codes, and the
// control-word field layout.
package control_sequencer_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int COUNT_WIDTH  = 5;
    localparam int CTRL_WORD_W  = 32;
    localparam int OUT_EN_W     = 10;
    localparam int IN_WE_W      = 7;
    localparam int REG_IDX_W    = 5;

    typedef enum logic [5:0] {
        OP_RESET = 6'h00,
        OP_FETCH = 6'h01,
        OP_ADDU  = 6'h03,
        OP_LHU   = 6'h25
    } opcode_e;

    // Source planes; 10..15 are not wired to any driver.
    localparam logic [3:0] OUT_PLANE_NONE  = 4'd0;
    localparam logic [3:0] OUT_PLANE_CTRL  = 4'd8;
    localparam logic [3:0] OUT_PLANE_IMM16 = 4'd9;
    localparam logic [3:0] OUT_PLANE_COUNT = 4'd10;

    // Sink planes; only OPWORD and OPCODE touch sequencer state.
    localparam logic [2:0] IN_PLANE_NONE   = 3'd0;
    localparam logic [2:0] IN_PLANE_OPWORD = 3'd5;
    localparam logic [2:0] IN_PLANE_OPCODE = 3'd6;

    localparam logic [1:0] REG_SEL_HI   = 2'd0;   // opword[25:21]
    localparam logic [1:0] REG_SEL_MID  = 2'd1;   // opword[20:16]
    localparam logic [1:0] REG_SEL_LO   = 2'd2;   // opword[15:11]
    localparam logic [1:0] REG_SEL_CTRL = 2'd3;   // ctrl_data[4:0]

    localparam logic MISC_STEP = 1'b0;
    localparam logic MISC_END  = 1'b1;

    typedef struct packed {
        logic [8:0] rsvd;
        logic       opcode_sel;
        logic [1:0] shifter;
        logic       mlu_carry;
        logic [2:0] mlu_op;
        logic       misc;
        logic [2:0] in_plane;
        logic [3:0] out_plane;
        logic [1:0] reg_sel;
        logic [5:0] ctrl_data;
    } ctrl_word_t;

    // True when an out_plane code names a real bus source.
    function automatic logic out_plane_valid(input logic [3:0] plane);
        return plane < OUT_PLANE_COUNT;
    endfunction

endpackage

// File: rtl/ctrl_word_decoder.sv
// Combinational decode of one microcode control word into unit enables,
// register index and the value this block drives onto the shared bus.
module ctrl_word_decoder
    import control_sequencer_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  ctrl_word_t             word_i,
    input  logic [WORD_W-1:0]      opword_i,
    input  logic                   stall_i,
    output logic [WORD_W-1:0]      bus_out_o,
    output logic                   bus_oe_o,
    output logic [REG_IDX_W-1:0]   reg_idx_o,
    output logic [OUT_EN_W-1:0]    out_en_o,
    output logic [IN_WE_W-1:0]     in_we_o,
    output logic [2:0]             mlu_op_o,
    output logic                   mlu_carry_o,
    output logic [1:0]             shift_ctl_o,
    output logic                   bad_plane_o
);

    // Fields consumed by the sequencer rather than by this decode.
    logic unused_fields;
    assign unused_fields = ^{word_i.rsvd, word_i.misc, word_i.opcode_sel,
                             opword_i[WORD_W-1:26]};

    assign mlu_op_o    = word_i.mlu_op;
    assign mlu_carry_o = word_i.mlu_carry;
    assign shift_ctl_o = word_i.shifter;

    // Source select and bus drive; unwired planes raise bad_plane_o.
    always_comb begin
        out_en_o    = '0;
        bad_plane_o = 1'b0;
        bus_out_o   = '0;
        bus_oe_o    = 1'b0;
        if (out_plane_valid(word_i.out_plane)) begin
            out_en_o = OUT_EN_W'(1) << word_i.out_plane;
        end else begin
            bad_plane_o = 1'b1;
        end
        case (word_i.out_plane)
            OUT_PLANE_CTRL: begin
                bus_out_o = WORD_W'(word_i.ctrl_data);
                bus_oe_o  = 1'b1;
            end
            OUT_PLANE_IMM16: begin
                bus_out_o = WORD_W'(opword_i[15:0]);
                bus_oe_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sink write enables; plane 7 has no bit in the 7-wide vector so it
    // decodes to no enable. A stall suppresses every write.
    always_comb begin
        in_we_o = '0;
        if (!stall_i) begin
            in_we_o = IN_WE_W'(1) << word_i.in_plane;
        end
    end

    // Register index from one of the opword register fields or ctrl_data.
    always_comb begin
        reg_idx_o = word_i.ctrl_data[4:0];
        case (word_i.reg_sel)
            REG_SEL_HI:   reg_idx_o = opword_i[25:21];
            REG_SEL_MID:  reg_idx_o = opword_i[20:16];
            REG_SEL_LO:   reg_idx_o = opword_i[15:11];
            REG_SEL_CTRL: reg_idx_o = word_i.ctrl_data[4:0];
            default:      reg_idx_o = word_i.ctrl_data[4:0];
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-op sequencer: owns opcode, micro-op count and opword, addresses the
// microcode store with {opcode, count} and decodes the returned word.
// A step that neither ends the instruction nor leaves count 31 simply
// advances; running off the end of a routine is a fault that returns to
// OP_RESET, so an empty opcode recovers on its own.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_WIDTH,
    parameter int COUNT_W  = COUNT_WIDTH,
    parameter int WORD_W   = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          STALL,
    output logic [OPCODE_W+COUNT_W-1:0]   UCODE_ADDR,
    input  logic [CTRL_WORD_W-1:0]        UCODE_WORD,
    input  logic [WORD_W-1:0]             BUS_IN,
    output logic [WORD_W-1:0]             BUS_OUT,
    output logic                          BUS_OE,
    output logic [REG_IDX_W-1:0]          REG_IDX,
    output logic [OUT_EN_W-1:0]           OUT_EN,
    output logic [IN_WE_W-1:0]            IN_WE,
    output logic [2:0]                    MLU_OP,
    output logic                          MLU_CARRY,
    output logic [1:0]                    SHIFT_CTL,
    output logic                          FAULT
);

    ctrl_word_t          word;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0]   opword_q, opword_d;
    logic                fault_q, fault_d;
    logic                bad_plane;

    assign word       = ctrl_word_t'(UCODE_WORD);
    assign UCODE_ADDR = {opcode_q, count_q};
    assign FAULT      = fault_q;

    ctrl_word_decoder #(
        .WORD_W (WORD_W)
    ) u_decoder (
        .word_i      (word),
        .opword_i    (opword_q),
        .stall_i     (STALL),
        .bus_out_o   (BUS_OUT),
        .bus_oe_o    (BUS_OE),
        .reg_idx_o   (REG_IDX),
        .out_en_o    (OUT_EN),
        .in_we_o     (IN_WE),
        .mlu_op_o    (MLU_OP),
        .mlu_carry_o (MLU_CARRY),
        .shift_ctl_o (SHIFT_CTL),
        .bad_plane_o (bad_plane)
    );

    // Next-state for opcode/count/opword/fault; everything holds while stalled.
    // Opcode load is taken from the opword as it stood before this edge.
    always_comb begin
        opcode_d = opcode_q;
        count_d  = count_q;
        opword_d = opword_q;
        fault_d  = fault_q;
        if (!STALL) begin
            if (word.in_plane == IN_PLANE_OPWORD) begin
                opword_d = BUS_IN;
            end
            if (word.in_plane == IN_PLANE_OPCODE) begin
                opcode_d = word.opcode_sel ? BUS_IN[OPCODE_W-1:0]
                                           : opword_q[WORD_W-1 -: OPCODE_W];
            end
            if (word.misc == MISC_END) begin
                count_d = '0;
            end else if (count_q == {COUNT_W{1'b1}}) begin
                // Routine ran past its last step: abandon it rather than wrap.
                fault_d  = 1'b1;
                opcode_d = OPCODE_W'(OP_RESET);
                count_d  = '0;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
            if (bad_plane) begin
                fault_d = 1'b1;
            end
        end
    end

    // Sequencer registers with synchronous reset taking priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            opcode_q <= OPCODE_W'(OP_RESET);
            count_q  <= '0;
            opword_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            count_q  <= count_d;
            opword_q <= opword_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a microcode ROM feeds the DUT, the bus loops
// back when the DUT drives it, and a rule-level model predicts every output.
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RST, STALL;
    logic [10:0] UCODE_ADDR;
    logic [31:0] UCODE_WORD, BUS_IN, BUS_OUT, bus_ext;
    logic        BUS_OE, MLU_CARRY, FAULT;
    logic [4:0]  REG_IDX;
    logic [9:0]  OUT_EN;
    logic [6:0]  IN_WE;
    logic [2:0]  MLU_OP;
    logic [1:0]  SHIFT_CTL;

    logic [31:0] rom [2048];

    int n_total = 0;
    int n_bad   = 0;

    // Model state: opcode, micro-op count, opword, fault.
    int          m_op, m_cnt, m_fault;
    logic [31:0] m_opword;

    always #5 CLK = ~CLK;

    assign UCODE_WORD = rom[UCODE_ADDR];
    assign BUS_IN     = BUS_OE ? BUS_OUT : bus_ext;

    control_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .STALL      (STALL),
        .UCODE_ADDR (UCODE_ADDR),
        .UCODE_WORD (UCODE_WORD),
        .BUS_IN     (BUS_IN),
        .BUS_OUT    (BUS_OUT),
        .BUS_OE     (BUS_OE),
        .REG_IDX    (REG_IDX),
        .OUT_EN     (OUT_EN),
        .IN_WE      (IN_WE),
        .MLU_OP     (MLU_OP),
        .MLU_CARRY  (MLU_CARRY),
        .SHIFT_CTL  (SHIFT_CTL),
        .FAULT      (FAULT)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] uw(int cd, int rs, int op, int ip, int misc, int sel);
        return 32'(cd | (rs << 6) | (op << 8) | (ip << 12) | (misc << 15) | (sel << 22));
    endfunction

    function automatic logic [31:0] cur_word();
        return rom[m_op * 32 + m_cnt];
    endfunction

    // What the block should put on the bus for word w.
    function automatic void exp_bus(input logic [31:0] w, output logic [31:0] b, output logic oe);
        int op;
        op = int'((w >> 8) & 15);
        b  = 32'h0;
        oe = 1'b0;
        if (op == 8) begin
            b  = w & 32'h3F;
            oe = 1'b1;
        end else if (op == 9) begin
            b  = m_opword & 32'hFFFF;
            oe = 1'b1;
        end
    endfunction

    task automatic compare_all();
        logic [31:0] w, eb;
        logic        eoe;
        int          cd, rs, op, ip, eri;
        w  = cur_word();
        cd = int'(w & 63);
        rs = int'((w >> 6) & 3);
        op = int'((w >> 8) & 15);
        ip = int'((w >> 12) & 7);
        exp_bus(w, eb, eoe);
        case (rs)
            0:       eri = int'((m_opword >> 21) & 31);
            1:       eri = int'((m_opword >> 16) & 31);
            2:       eri = int'((m_opword >> 11) & 31);
            default: eri = cd & 31;
        endcase
        check_val("addr",    32'(UCODE_ADDR), m_op * 32 + m_cnt);
        check_val("out_en",  32'(OUT_EN),     (op <= 9) ? (1 << op) : 0);
        check_val("in_we",   32'(IN_WE),      STALL ? 0 : ((1 << ip) & 'h7F));
        check_val("bus_out", BUS_OUT,         eb);
        check_val("bus_oe",  32'(BUS_OE),     32'(eoe));
        check_val("reg_idx", 32'(REG_IDX),    eri);
        check_val("mlu_op",  32'(MLU_OP),     (w >> 16) & 7);
        check_val("carry",   32'(MLU_CARRY),  (w >> 19) & 1);
        check_val("shift",   32'(SHIFT_CTL),  (w >> 20) & 3);
        check_val("fault",   32'(FAULT),      m_fault);
    endtask

    task automatic model_update(input logic rst, input logic stall, input logic [31:0] ext);
        logic [31:0] w, eb, bus, n_opw;
        logic        eoe;
        int          op, ip, n_op, n_cnt;
        w  = cur_word();
        op = int'((w >> 8) & 15);
        ip = int'((w >> 12) & 7);
        exp_bus(w, eb, eoe);
        bus = eoe ? eb : ext;
        if (rst) begin
            m_op = 0; m_cnt = 0; m_opword = 0; m_fault = 0;
        end else if (!stall) begin
            n_opw = m_opword;
            n_op  = m_op;
            if (ip == 5) n_opw = bus;
            if (ip == 6) n_op = w[22] ? int'(bus & 63) : int'(m_opword >> 26);
            if (w[15]) n_cnt = 0;
            else if (m_cnt == 31) begin
                m_fault = 1; n_op = 0; n_cnt = 0;
            end else n_cnt = m_cnt + 1;
            if (op >= 10) m_fault = 1;
            m_op = n_op; m_cnt = n_cnt; m_opword = n_opw;
        end
    endtask

    task automatic tick(input logic rst, input logic stall, input logic [31:0] ext);
        @(negedge CLK);
        RST = rst; STALL = stall; bus_ext = ext;
        #1;
        compare_all();
        @(posedge CLK);
        model_update(rst, stall, ext);
        #1;
    endtask

    task automatic run_fetch(input logic [31:0] opw);
        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, opw);
        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);
    endtask

    initial begin
        logic [31:0] r, ext;
        logic        rst, stall;

        for (int i = 0; i < 2048; i++) rom[i] = 32'h0;
        // Reset routine: idle step, then load OP_FETCH via bus loopback.
        rom[1]    = uw(1, 0, 8, 6, 1, 1);
        // Fetch: drive PC, latch opword, idle sink, dispatch from opword.
        rom[32]   = uw(0, 0, 1, 7, 0, 0);
        rom[33]   = uw(0, 0, 0, 5, 0, 0);
        rom[34]   = uw(0, 0, 0, 4, 0, 0);
        rom[35]   = uw(0, 0, 0, 6, 1, 0);
        // ADDU (3): read rS then rD with some MLU/shifter activity.
        rom[96]   = uw(0, 1, 2, 2, 0, 0) | (32'd5 << 16) | (32'd1 << 19);
        rom[97]   = uw(0, 0, 3, 3, 0, 0) | (32'd2 << 20);
        rom[98]   = uw(1, 0, 8, 6, 1, 1);
        // LHU (0x25): drive immediate, then return to fetch.
        rom[1184] = uw(0, 0, 9, 1, 0, 0);
        rom[1185] = uw(1, 0, 8, 6, 1, 1);
        // Opcodes 8..15 hold random control words.
        for (int i = 256; i < 512; i++) rom[i] = $urandom;

        RST = 1'b1; STALL = 1'b0; bus_ext = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        m_op = 0; m_cnt = 0; m_opword = 0; m_fault = 0;
        check_val("rst_addr",  32'(UCODE_ADDR), 32'h000);
        check_val("rst_fault", 32'(FAULT),      32'h0);
        tick(1'b1, 1'b0, $urandom);

        tick(1'b0, 1'b0, $urandom);
        check_val("boot_step1", 32'(UCODE_ADDR), 32'h001);
        tick(1'b0, 1'b0, $urandom);
        check_val("boot_fetch", 32'(UCODE_ADDR), 32'h020);

        run_fetch(32'h0C22_0005);
        check_val("addu_addr", 32'(UCODE_ADDR), 32'h060);
        check_val("addu_rs",   32'(REG_IDX),    32'd2);
        tick(1'b0, 1'b0, $urandom);
        check_val("addu_rd",   32'(REG_IDX),    32'd1);
        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);
        check_val("addu_ret",  32'(UCODE_ADDR), 32'h020);

        run_fetch(32'h9400_BEEF);
        check_val("lhu_addr",  32'(UCODE_ADDR), 32'h4A0);
        check_val("lhu_bus",   BUS_OUT,         32'h0000_BEEF);
        check_val("lhu_oe",    32'(BUS_OE),     32'h1);
        check_val("lhu_we",    32'(IN_WE),      32'h02);
        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);

        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, 32'h0C22_0005);
        check_val("stall_pre", 32'(UCODE_ADDR), 32'h022);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, $urandom);
            check_val("stall_addr", 32'(UCODE_ADDR), 32'h022);
            check_val("stall_we",   32'(IN_WE),      32'h0);
        end
        tick(1'b0, 1'b0, $urandom);
        check_val("stall_resume", 32'(UCODE_ADDR), 32'h023);
        tick(1'b0, 1'b0, $urandom);
        repeat (3) tick(1'b0, 1'b0, $urandom);

        run_fetch(32'hFC00_0000);
        check_val("undef_addr", 32'(UCODE_ADDR), 32'h7E0);
        repeat (31) tick(1'b0, 1'b0, $urandom);
        check_val("undef_last", 32'(UCODE_ADDR), 32'h7FF);
        check_val("undef_nf",   32'(FAULT),      32'h0);
        tick(1'b0, 1'b0, $urandom);
        check_val("undef_fault", 32'(FAULT),      32'h1);
        check_val("undef_home",  32'(UCODE_ADDR), 32'h000);

        tick(1'b0, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);
        repeat (3) tick(1'b0, 1'b0, $urandom);
        check_val("mid_step3", 32'(UCODE_ADDR), 32'h023);
        tick(1'b1, 1'b0, $urandom);
        check_val("mid_rst_addr",  32'(UCODE_ADDR), 32'h000);
        check_val("mid_rst_fault", 32'(FAULT),      32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 3) == 0);
            r     = $urandom;
            case ($urandom_range(0, 4))
                0:       ext = {6'h03, r[25:0]};
                1:       ext = {6'h25, r[25:0]};
                2:       ext = {3'b001, r[28:0]};
                default: ext = r;
            endcase
            tick(rst, stall, ext);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
